// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, opcodes and fetch FSM states
package riscv_pkg;
    localparam int ILEN = 32;
    localparam logic [6:0] OPCODE_NOP = 7'b0000000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {RESET_HOLD, FETCH, REDIRECT} fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold, bubble and load
import riscv_pkg::*;
module if_id_reg (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            hold,
    input  logic            load,
    input  logic [31:0]     pc,
    input  logic [ILEN-1:0] instr,
    output logic            valid,
    output logic [31:0]     pc_q,
    output logic [ILEN-1:0] instr_q
);
    always_ff @(posedge clk) begin
        if (rst || flush || (!hold && !load)) begin
            valid   <= 1'b0;
            pc_q    <= '0;
            instr_q <= {{(ILEN-7){1'b0}}, OPCODE_NOP};
        end else if (!hold) begin
            valid   <= 1'b1;
            pc_q    <= pc;
            instr_q <= instr;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC and fetch FSM feeding the IF/ID register and field decode
import riscv_pkg::*;
module fetch_stage #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_ready,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            flush,
    input  logic [31:0]     redirect_pc,
    output logic            if_valid,
    output logic [31:0]     if_pc,
    output logic [ILEN-1:0] if_instr,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [19:0]     imm_data
);
    fetch_state_t state, state_next;
    logic [31:0] pc;
    logic hold, accept;
    assign hold      = stall && if_valid && !flush;
    assign imem_req  = (state == FETCH) && !(stall && if_valid) && !flush;
    assign accept    = imem_req && imem_ready;
    assign imem_addr = pc;
    always_comb begin
        state_next = FETCH;
        if (flush)
            state_next = REDIRECT;
    end
    always_ff @(posedge clk) begin
        state <= rst ? RESET_HOLD : state_next;
        if (rst)
            pc <= RESET_PC;
        else if (flush)
            pc <= {redirect_pc[31:2], 2'b00};
        else if (accept)
            pc <= pc + 32'd4;
    end
    if_id_reg u_if_id (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .hold(hold),
        .load(accept),
        .pc(pc),
        .instr(imem_rdata),
        .valid(if_valid),
        .pc_q(if_pc),
        .instr_q(if_instr)
    );
    assign opcode   = if_instr[6:0];
    assign func3    = if_instr[14:12];
    assign func7    = if_instr[31:25];
    assign imm_data = if_instr[31:12];
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage, two RESET_PC variants
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst, imem_ready, stall, flush;
    logic [31:0] imem_rdata, redirect_pc;
    logic req_a, valid_a, req_b, valid_b;
    logic [31:0] addr_a, pc_a, instr_a, addr_b, pc_b, instr_b;
    logic [6:0] op_a, f7_a, op_b, f7_b;
    logic [2:0] f3_a, f3_b;
    logic [19:0] imm_a, imm_b;
    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_stage dut_a (
        .clk(clk), .rst(rst), .imem_req(req_a), .imem_addr(addr_a),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
        .flush(flush), .redirect_pc(redirect_pc), .if_valid(valid_a),
        .if_pc(pc_a), .if_instr(instr_a), .opcode(op_a), .func3(f3_a),
        .func7(f7_a), .imm_data(imm_a)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst(rst), .imem_req(req_b), .imem_addr(addr_b),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
        .flush(flush), .redirect_pc(redirect_pc), .if_valid(valid_b),
        .if_pc(pc_b), .if_instr(instr_b), .opcode(op_b), .func3(f3_b),
        .func7(f7_b), .imm_data(imm_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h00A00093;
        stall = 1'b0; flush = 1'b0; redirect_pc = '0;
        step(); step();
        sample();
        chk("rst_valid", {31'b0, valid_a}, 0);
        chk("rst_pc", pc_a, 0);
        chk("rst_instr", instr_a, 0);
        chk("rst_req", {31'b0, req_a}, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_addr_b", addr_b, 32'hFFFF_FFFC);
        step(); rst = 1'b0;
        sample();
        chk("hold_req", {31'b0, req_a}, 0);
        step();
        sample();
        chk("f0_req", {31'b0, req_a}, 1);
        chk("f0_addr", addr_a, 0);
        chk("f0_addr_b", addr_b, 32'hFFFF_FFFC);
        step();
        sample();
        chk("f1_addr", addr_a, 4);
        chk("f1_valid", {31'b0, valid_a}, 1);
        chk("f1_pc", pc_a, 0);
        chk("f1_opcode", {25'b0, op_a}, 32'h13);
        chk("f1_imm", {12'b0, imm_a}, 32'h00A00);
        chk("f1_func3", {29'b0, f3_a}, 0);
        chk("wrap_pc_b", pc_b, 32'hFFFF_FFFC);
        chk("wrap_addr_b", addr_b, 0);
        step(); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("stall_req", {31'b0, req_a}, 0);
            chk("stall_addr", addr_a, 8);
            chk("stall_pc", pc_a, 4);
            chk("stall_instr", instr_a, 32'h00A00093);
            chk("stall_valid", {31'b0, valid_a}, 1);
            step();
        end
        stall = 1'b0; imem_ready = 1'b0;
        sample();
        chk("resume_req", {31'b0, req_a}, 1);
        chk("resume_addr", addr_a, 8);
        step();
        sample();
        chk("wait_addr", addr_a, 8);
        chk("wait_req", {31'b0, req_a}, 1);
        chk("wait_valid", {31'b0, valid_a}, 0);
        chk("wait_opcode", {25'b0, op_a}, 0);
        step(); imem_ready = 1'b1; imem_rdata = 32'hFE010113;
        sample();
        chk("wait2_addr", addr_a, 8);
        chk("wait2_valid", {31'b0, valid_a}, 0);
        chk("wait2_opcode", {25'b0, op_a}, 0);
        step();
        sample();
        chk("acc8_valid", {31'b0, valid_a}, 1);
        chk("acc8_pc", pc_a, 8);
        chk("acc8_func7", {25'b0, f7_a}, 32'h7F);
        chk("acc8_imm", {12'b0, imm_a}, 32'hFE010);
        chk("acc8_addr", addr_a, 12);
        step(); flush = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0103; imem_rdata = 32'h12345678;
        sample();
        chk("flush_req", {31'b0, req_a}, 0);
        step(); flush = 1'b0; stall = 1'b0;
        sample();
        chk("redir_valid", {31'b0, valid_a}, 0);
        chk("redir_instr", instr_a, 0);
        chk("redir_req", {31'b0, req_a}, 0);
        chk("redir_addr", addr_a, 32'h100);
        step(); imem_ready = 1'b0;
        sample();
        chk("post_redir_req", {31'b0, req_a}, 1);
        chk("post_redir_addr", addr_a, 32'h100);
        step(); rst = 1'b1;
        sample();
        chk("midwait_req", {31'b0, req_a}, 1);
        step(); rst = 1'b0; flush = 1'b1; redirect_pc = 32'h0000_0200;
        sample();
        chk("rst2_addr", addr_a, 0);
        chk("rst2_valid", {31'b0, valid_a}, 0);
        chk("rst2_req", {31'b0, req_a}, 0);
        chk("rst2_addr_b", addr_b, 32'hFFFF_FFFC);
        step(); redirect_pc = 32'h0000_0031;
        sample();
        chk("reflush_addr", addr_a, 32'h200);
        chk("reflush_req", {31'b0, req_a}, 0);
        step(); flush = 1'b0; imem_ready = 1'b1;
        sample();
        chk("reredir_addr", addr_a, 32'h30);
        chk("reredir_req", {31'b0, req_a}, 0);
        step();
        sample();
        chk("refetch_req", {31'b0, req_a}, 1);
        chk("refetch_addr", addr_a, 32'h30);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address; always equals the current PC.
REQ-006 imem_ready  input  1  imem_rdata is valid this cycle; ignored when imem_req=0.
REQ-007 imem_rdata  input  32  instruction word.
REQ-008 stall  input  1  decode cannot accept a new instruction.
REQ-009 flush  input  1  redirect fetch and discard the IF/ID contents.
REQ-010 redirect_pc  input  32  new PC, used when flush=1.
REQ-011 if_valid  output  1  IF/ID holds a real instruction.
REQ-012 if_pc  output  32  PC of the IF/ID instruction.
REQ-013 if_instr  output  32  raw IF/ID instruction.
REQ-014 opcode  output  7  if_instr[6:0].
REQ-015 func3  output  3  if_instr[14:12].
REQ-016 func7  output  7  if_instr[31:25].
REQ-017 imm_data  output  20  if_instr[31:12].

Function
REQ-018 The block SHALL implement a three-state FSM: RESET_HOLD, FETCH and REDIRECT.
REQ-019 RESET_HOLD SHALL last exactly one cycle after rst deasserts, with imem_req=0, and SHALL then go to FETCH.
REQ-020 In FETCH, imem_req SHALL be !(stall && if_valid) && !flush (combinational).
REQ-021 Accept SHALL be defined as imem_req && imem_ready; on accept, IF/ID SHALL load {instr, PC}, if_valid SHALL be set to 1 and PC SHALL become PC+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0).
REQ-022 When stall=1 and if_valid=1, IF/ID and PC SHALL hold.
REQ-023 When there is no accept and the hold condition of REQ-022 does not apply, IF/ID SHALL load a bubble: if_valid=0 and all instruction fields zero (opcode 0 = NOP).
REQ-024 While waiting for imem_ready, imem_req SHALL stay high and imem_addr SHALL stay stable.
REQ-025 flush SHALL have priority over stall, accept and imem_ready, in every state.
REQ-026 On flush: PC SHALL load {redirect_pc[31:2],2'b00}, IF/ID SHALL become a bubble, any same-cycle imem_rdata SHALL be discarded, and the FSM SHALL enter REDIRECT.
REQ-027 REDIRECT SHALL last one cycle with imem_req=0 and SHALL then go to FETCH.
REQ-028 A flush during REDIRECT SHALL reload PC with the new target and SHALL stay in REDIRECT for one further cycle.
REQ-029 All decode-facing outputs SHALL be registered; the minimum latency from accept to if_valid is 1 cycle.
REQ-030 The field mapping of REQ-014 to REQ-017 SHALL be purely combinational from if_instr.

Reset
REQ-031 On rst: PC=RESET_PC, if_valid=0, if_pc=0, if_instr=0 and FSM=RESET_HOLD.
REQ-032 rst SHALL override flush, stall and imem_ready.
REQ-033 An in-flight request SHALL be abandoned when rst asserts mid-fetch.

Structure
REQ-034 Package riscv_pkg SHALL hold ILEN=32, OPCODE_NOP=7'b0000000, the fetch_state_t enum and the default RESET_PC.
REQ-035 The IF/ID register (hold, bubble, load) SHALL be a sub-module named if_id_reg; the PC and FSM stay in fetch_stage.

Verification
REQ-036 Reset, then imem_ready=1 constantly with imem_rdata=32'h00A00093 -> imem_req=0 for 1 cycle, then imem_addr 0,4,8; if_valid=1 with if_pc=0, opcode=7'b0010011, imm_data=20'h00A00.
REQ-037 stall=1 for 3 cycles with if_valid=1 -> imem_req=0, if_pc/if_instr unchanged, PC unchanged; after release, the next fetch resumes at the held PC.
REQ-038 imem_ready=0 for 2 cycles at PC=8 -> imem_addr=8 held, if_valid=0 and opcode=0 for those cycles, then the instruction at 8 is accepted.
REQ-039 flush=1 with redirect_pc=32'h0000_0103 while imem_ready=1 and stall=1 -> returned data dropped, if_valid=0 next cycle, one dead cycle, next imem_addr=32'h0000_0100.
REQ-040 RESET_PC=32'hFFFF_FFFC, one accept -> if_pc=32'hFFFF_FFFC, next imem_addr=0.
REQ-041 rst asserted mid-wait with imem_req=1 -> next cycle PC=RESET_PC, if_valid=0, imem_req=0.
